regfile_wb_arbiter: RTL and testbench

Shares the single write port of the 8x16 register file between two writeback sources: A (ALU result) and B (load/memory result). Arbitration is round-robin over valid/ready handshakes, and the granted write is driven on registered RegWrite/WriteReg/WriteData outputs. A per-register pending-write scoreboard (busy vector) lets the issue stage stall on RAW hazards. The block sits between the execute/memory stages and the register file write port.

---
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single write port of the register file between two writeback
// sources: A (ALU result) and B (load/memory result). The two sources are
// arbitrated round-robin over valid/ready handshakes. The granted write is
// presented one cycle later on registered RegWrite/WriteReg/WriteData outputs.
// A per-register busy vector tracks outstanding writes so that the issue
// stage can stall on RAW hazards.
//
// Ports
//   clock, reset              : system clock, synchronous active-high reset
//   mark_valid, mark_reg      : issue stage marks a destination as pending
//   a_valid/a_reg/a_data      : source A request,  a_ready = accepted
//   b_valid/b_reg/b_data      : source B request,  b_ready = accepted
//   RegWrite/WriteReg/WriteData : registered register-file write port
//   busy                      : bit r set while register r has a pending write
//   err                       : sticky protocol error (double mark, or
//                               writeback to an unmarked register)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mark_valid,
    input  logic [ADDR_WIDTH-1:0]     mark_reg,
    input  logic                      a_valid,
    input  logic [ADDR_WIDTH-1:0]     a_reg,
    input  logic [DATA_WIDTH-1:0]     a_data,
    output logic                      a_ready,
    input  logic                      b_valid,
    input  logic [ADDR_WIDTH-1:0]     b_reg,
    input  logic [DATA_WIDTH-1:0]     b_data,
    output logic                      b_ready,
    output logic                      RegWrite,
    output logic [ADDR_WIDTH-1:0]     WriteReg,
    output logic [DATA_WIDTH-1:0]     WriteData,
    output logic [2**ADDR_WIDTH-1:0]  busy,
    output logic                      err
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    src_e                  last_grant_q, last_grant_d;
    logic                  reg_write_q,  reg_write_d;
    logic [ADDR_WIDTH-1:0] write_reg_q,  write_reg_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [NREGS-1:0]      busy_q,       busy_d;
    logic                  err_q,        err_d;

    logic                  grant_a;
    logic                  grant_b;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_reg;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  clear_hits_mark;

    // On a tie the source that did not win last time is granted; a lone
    // requester is always granted, so at most one ready is ever high.
    always_comb begin
        grant_a  = a_valid && (!b_valid || (last_grant_q == SRC_B));
        grant_b  = b_valid && (!a_valid || (last_grant_q == SRC_A));
        xfer     = grant_a || grant_b;
        sel_reg  = grant_a ? a_reg  : b_reg;
        sel_data = grant_a ? a_data : b_data;
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_comb begin
        last_grant_d = last_grant_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = xfer;
        if (xfer) begin
            write_reg_d  = sel_reg;
            write_data_d = sel_data;
            last_grant_d = grant_a ? SRC_A : SRC_B;
        end
    end

    // A register being retired on this very edge may be re-marked legally.
    always_comb begin
        clear_hits_mark = reg_write_q && (write_reg_q == mark_reg);
        err_d = err_q
              || (mark_valid && busy_q[mark_reg] && !clear_hits_mark)
              || (xfer && !busy_q[sel_reg]);
    end

    // Per-register scoreboard bit: the set term is OR-ed after the clear so a
    // same-edge set and clear on one register leaves it pending.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi = gi + 1) begin : g_busy
            assign busy_d[gi] = (mark_valid && (mark_reg == ADDR_WIDTH'(gi)))
                             || (busy_q[gi] && !(reg_write_q && (write_reg_q == ADDR_WIDTH'(gi))));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= SRC_B;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign RegWrite  = reg_write_q;
    assign WriteReg  = write_reg_q;
    assign WriteData = write_data_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_wb_arbiter: table-driven vectors for the basic grant
// sequences plus hand-written sequences for alternation, scoreboard races,
// unmarked writebacks and reset during traffic. Accepted writes are pushed to
// a scoreboard queue and popped when RegWrite appears.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mark_valid = 1'b0;
    logic [2:0]  mark_reg = '0;
    logic        a_valid = 1'b0;
    logic [2:0]  a_reg = '0;
    logic [15:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [2:0]  b_reg = '0;
    logic [15:0] b_data = '0;
    logic        b_ready;
    logic        RegWrite;
    logic [2:0]  WriteReg;
    logic [15:0] WriteData;
    logic [7:0]  busy;
    logic        err;

    regfile_wb_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clock(clock), .reset(reset),
        .mark_valid(mark_valid), .mark_reg(mark_reg),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          rst;
        bit          mv;
        logic [2:0]  mr;
        bit          av;
        logic [2:0]  ar;
        logic [15:0] ad;
        bit          bv;
        logic [2:0]  br;
        logic [15:0] bd;
        bit          ea;
        bit          eb;
    } vec_t;

    typedef struct {
        logic [2:0]  r;
        logic [15:0] d;
    } wr_t;

    int n_checks = 0;
    int n_err    = 0;
    int n_txn    = 0;

    // reference model state
    logic [7:0]  m_busy  = '0;
    bit          m_err   = 1'b0;
    bit          m_rw    = 1'b0;
    logic [2:0]  m_wreg  = '0;
    logic [15:0] m_wdata = '0;
    wr_t         sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = '0;
        m_err   = 1'b0;
        m_rw    = 1'b0;
        m_wreg  = '0;
        m_wdata = '0;
        sb_q.delete();
    endtask

    // One reset cycle with both requesters optionally valid.
    task automatic do_reset(input bit av, input bit bv);
        reset      = 1'b1;
        mark_valid = 1'b0;
        a_valid    = av;
        b_valid    = bv;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        model_reset();
        check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("rst_writereg", {29'd0, WriteReg}, 32'd0);
        check("rst_writedata", {16'd0, WriteData}, 32'd0);
        check("rst_busy", {24'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        $display("txn %0d reset: RegWrite=%0b busy=%02h err=%0b", n_txn, RegWrite, busy, err);
        n_txn++;
    endtask

    // Drive one cycle of stimulus, check readies against the expected grant,
    // then advance the model across the edge and check the registered outputs.
    task automatic cycle(input bit mv, input logic [2:0] mr,
                         input bit av, input logic [2:0] ar, input logic [15:0] ad,
                         input bit bv, input logic [2:0] br, input logic [15:0] bd,
                         input bit ea, input bit eb);
        logic [7:0]  nb;
        logic [2:0]  r;
        logic [15:0] d;
        wr_t         w;
        mark_valid = mv; mark_reg = mr;
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        #2;
        check("a_ready", {31'd0, a_ready}, {31'd0, ea});
        check("b_ready", {31'd0, b_ready}, {31'd0, eb});
        check("ready_exclusive", {31'd0, a_ready & b_ready}, 32'd0);
        check("ready_needs_valid", {31'd0, (a_ready & ~a_valid) | (b_ready & ~b_valid)}, 32'd0);
        @(posedge clock);
        nb = m_busy;
        if (m_rw) nb[m_wreg] = 1'b0;
        if (mv) begin
            if (m_busy[mr] && !(m_rw && m_wreg == mr)) m_err = 1'b1;
            nb[mr] = 1'b1;
        end
        r = ea ? ar : br;
        d = ea ? ad : bd;
        if (ea || eb) begin
            if (!m_busy[r]) m_err = 1'b1;
            w.r = r;
            w.d = d;
            sb_q.push_back(w);
            m_wreg  = r;
            m_wdata = d;
        end
        m_rw   = ea || eb;
        m_busy = nb;
        #1;
        check("regwrite", {31'd0, RegWrite}, {31'd0, m_rw});
        if (m_rw) begin
            if (sb_q.size() == 0) begin
                check("scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
                w = sb_q.pop_front();
                check("sb_writereg", {29'd0, WriteReg}, {29'd0, w.r});
                check("sb_writedata", {16'd0, WriteData}, {16'd0, w.d});
            end
        end
        check("writereg_hold", {29'd0, WriteReg}, {29'd0, m_wreg});
        check("writedata_hold", {16'd0, WriteData}, {16'd0, m_wdata});
        check("busy", {24'd0, busy}, {24'd0, m_busy});
        check("err", {31'd0, err}, {31'd0, m_err});
        $display("txn %0d mark=%0b/%0d a=%0b/%0d/%04h b=%0b/%0d/%04h rdy=%0b%0b -> RegWrite=%0b WriteReg=%0d WriteData=%04h busy=%02h err=%0b",
                 n_txn, mv, mr, av, ar, ad, bv, br, bd, ea, eb,
                 RegWrite, WriteReg, WriteData, busy, err);
        n_txn++;
    endtask

    task automatic idle();
        cycle(0, 3'd0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0);
    endtask

    task automatic mark(input logic [2:0] r);
        cycle(1, r, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0);
    endtask

    function automatic vec_t mk(bit rst, bit mv, logic [2:0] mr,
                                bit av, logic [2:0] ar, logic [15:0] ad,
                                bit bv, logic [2:0] br, logic [15:0] bd,
                                bit ea, bit eb);
        vec_t v;
        v.rst = rst; v.mv = mv; v.mr = mr;
        v.av = av; v.ar = ar; v.ad = ad;
        v.bv = bv; v.br = br; v.bd = bd;
        v.ea = ea; v.eb = eb;
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        // basic single write, then the A-first tie after reset
        vecs[0]  = mk(1, 0, 3'd0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);
        vecs[1]  = mk(0, 1, 3'd3, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);
        vecs[2]  = mk(0, 0, 3'd0, 1, 3'd3, 16'h1234, 0, 3'd0, 16'h0000, 1, 0);
        vecs[3]  = mk(0, 0, 3'd0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);
        vecs[4]  = mk(0, 0, 3'd0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);
        vecs[5]  = mk(1, 0, 3'd0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);
        vecs[6]  = mk(0, 1, 3'd1, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);
        vecs[7]  = mk(0, 1, 3'd2, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);
        vecs[8]  = mk(0, 0, 3'd0, 1, 3'd1, 16'hAAAA, 1, 3'd2, 16'hBBBB, 1, 0);
        vecs[9]  = mk(0, 0, 3'd0, 0, 3'd0, 16'h0000, 1, 3'd2, 16'hBBBB, 0, 1);
        vecs[10] = mk(0, 0, 3'd0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);
        vecs[11] = mk(0, 0, 3'd0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);

        @(posedge clock);
        #1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].rst)
                do_reset(0, 0);
            else
                cycle(vecs[i].mv, vecs[i].mr, vecs[i].av, vecs[i].ar, vecs[i].ad,
                      vecs[i].bv, vecs[i].br, vecs[i].bd, vecs[i].ea, vecs[i].eb);
        end
        check("t1t2_busy_clear", {24'd0, busy}, 32'd0);

        // Alternation: last grant was B, so A,B,A,B,A,B.
        for (int i = 0; i < 6; i++) mark(3'(i));
        begin
            int ia;
            int ib;
            ia = 0;
            ib = 0;
            for (int k = 0; k < 6; k++) begin
                bit ga;
                ga = (k % 2) == 0;
                cycle(0, 3'd0,
                      1, 3'(2 * ia),     16'hA000 + 16'(ia),
                      1, 3'(2 * ib + 1), 16'hB000 + 16'(ib),
                      ga, !ga);
                if (ga) ia++; else ib++;
            end
        end
        idle();
        idle();
        check("t3_busy_clear", {24'd0, busy}, 32'd0);
        check("t3_err_clean", {31'd0, err}, 32'd0);

        // Re-mark on the retiring edge: set wins, no error; then double mark.
        mark(3'd5);
        cycle(0, 3'd0, 1, 3'd5, 16'h5555, 0, 3'd0, 16'h0, 1, 0);
        mark(3'd5);
        check("t4_busy5_kept", {31'd0, busy[5]}, 32'd1);
        check("t4_no_err", {31'd0, err}, 32'd0);
        mark(3'd5);
        check("t4_double_mark_err", {31'd0, err}, 32'd1);
        idle();
        idle();
        check("t4_err_sticky", {31'd0, err}, 32'd1);

        // Unmarked writeback from B: write still happens, error raised.
        do_reset(0, 0);
        cycle(0, 3'd0, 0, 3'd0, 16'h0, 1, 3'd6, 16'h0F0F, 0, 1);
        check("t5_writereg", {29'd0, WriteReg}, 32'd6);
        check("t5_writedata", {16'd0, WriteData}, 32'h0F0F);
        check("t5_err", {31'd0, err}, 32'd1);
        idle();

        // Reset during traffic with every register pending.
        do_reset(0, 0);
        for (int i = 0; i < 8; i++) mark(3'(i));
        check("t6_busy_full", {24'd0, busy}, 32'hFF);
        a_reg = 3'd0; a_data = 16'h1111;
        b_reg = 3'd7; b_data = 16'h7777;
        do_reset(1, 1);
        mark(3'd0);
        mark(3'd7);
        cycle(0, 3'd0, 1, 3'd0, 16'h1111, 1, 3'd7, 16'h7777, 1, 0);
        cycle(0, 3'd0, 0, 3'd0, 16'h0,    1, 3'd7, 16'h7777, 0, 1);
        idle();
        idle();
        check("t6_busy_end", {24'd0, busy}, 32'd0);
        check("t6_err_end", {31'd0, err}, 32'd0);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
